// File: rtl/activity_controller.sv
// -----------------------------------------------------------------------------
// activity_controller
//
// Purpose:
//   Turns four raw push-buttons into an activity mode (IDLE/RUN/WALK/CYCLE).
//   It also gates a free-running one-second tick into per-activity
//   count-enable pulses for the stopwatch.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_run      in   raw run button, active-high
//   btn_walk     in   raw walk button, active-high
//   btn_cycle    in   raw cycle button, active-high
//   btn_stop     in   raw stop button, active-high
//   Run          out  tick pulse while in RUN
//   Walk         out  tick pulse while in WALK
//   Cycle        out  tick pulse while in CYCLE
//   tick         out  one-cycle pulse every TICK_DIV cycles
//   active_mode  out  00 IDLE, 01 RUN, 10 WALK, 11 CYCLE
//   mode_change  out  one-cycle pulse whenever the mode changes
// -----------------------------------------------------------------------------
module activity_controller #(
  parameter int TICK_DIV  = 100,
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_walk,
  input  logic       btn_cycle,
  input  logic       btn_stop,
  output logic       Run,
  output logic       Walk,
  output logic       Cycle,
  output logic       tick,
  output logic [1:0] active_mode,
  output logic       mode_change
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_WALK  = 2'b10,
    S_CYCLE = 2'b11
  } state_t;

  localparam int BTN_STOP  = 0;
  localparam int BTN_RUN   = 1;
  localparam int BTN_WALK  = 2;
  localparam int BTN_CYCLE = 3;

  localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [3:0]  w_rawBtn;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_dbLevel;
  logic [3:0]  r_dbLevelQ;
  logic [7:0]  r_dbCount [4];
  logic [3:0]  w_press;
  logic [15:0] r_prescCount;
  logic        r_tick;
  state_t      r_state;
  state_t      w_nextState;
  logic        r_modeChange;

  assign w_rawBtn = {btn_cycle, btn_walk, btn_run, btn_stop};

  // Two-flop synchronizer per button so the raw asynchronous inputs never
  // reach the debounce logic while they might still be metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_rawBtn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the accepted level only follows the synchronized level after
  // DB_CYCLES consecutive disagreeing cycles. Any return to agreement clears
  // the count, so a bouncing contact keeps restarting it. The previous
  // accepted level is kept so that only rising edges become presses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbLevel  <= '0;
      r_dbLevelQ <= '0;
      for (int i = 0; i < 4; i++) begin
        r_dbCount[i] <= '0;
      end
    end else begin
      r_dbLevelQ <= r_dbLevel;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_dbLevel[i]) begin
          r_dbCount[i] <= '0;
        end else if (r_dbCount[i] == DB_LAST) begin
          r_dbLevel[i] <= r_sync2[i];
          r_dbCount[i] <= '0;
        end else begin
          r_dbCount[i] <= r_dbCount[i] + 8'd1;
        end
      end
    end
  end

  assign w_press = r_dbLevel & ~r_dbLevelQ;

  // Free-running prescaler. The tick is registered, so it lands on the cycle
  // after the count sits at its last value, which is also the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescCount <= '0;
      r_tick       <= 1'b0;
    end else if (r_prescCount == TICK_LAST) begin
      r_prescCount <= '0;
      r_tick       <= 1'b1;
    end else begin
      r_prescCount <= r_prescCount + 16'd1;
      r_tick       <= 1'b0;
    end
  end

  // Mode state register, plus the registered change flag that lines up with
  // the first cycle the new mode is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_modeChange <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_modeChange <= (w_nextState != r_state);
    end
  end

  // Next-state selection. The if-chain order is the press priority:
  // stop beats run beats walk beats cycle, and losing presses are dropped.
  // Pressing the button of the current activity pauses back to IDLE.
  always_comb begin
    w_nextState = r_state;
    if (w_press[BTN_STOP]) begin
      w_nextState = S_IDLE;
    end else if (w_press[BTN_RUN]) begin
      w_nextState = (r_state == S_RUN) ? S_IDLE : S_RUN;
    end else if (w_press[BTN_WALK]) begin
      w_nextState = (r_state == S_WALK) ? S_IDLE : S_WALK;
    end else if (w_press[BTN_CYCLE]) begin
      w_nextState = (r_state == S_CYCLE) ? S_IDLE : S_CYCLE;
    end
  end

  // Outputs decode the registered state, so a tick that coincides with a
  // mode change is still credited to the mode being left.
  always_comb begin
    Run         = (r_state == S_RUN)   & r_tick;
    Walk        = (r_state == S_WALK)  & r_tick;
    Cycle       = (r_state == S_CYCLE) & r_tick;
    tick        = r_tick;
    active_mode = r_state;
    mode_change = r_modeChange;
  end

endmodule

// File: tb/tb_activity_controller.sv
// -----------------------------------------------------------------------------
// tb_activity_controller
//
// Purpose:
//   Directed self-checking bench for activity_controller with TICK_DIV=10 and
//   DB_CYCLES=4. Outputs are sampled 1 ns after each rising edge.
//
// Ports: none (top-level bench)
// -----------------------------------------------------------------------------
module tb_activity_controller;

  localparam int TICK_DIV  = 10;
  localparam int DB_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_walk = 1'b0;
  logic       btn_cycle = 1'b0;
  logic       btn_stop = 1'b0;
  logic       Run;
  logic       Walk;
  logic       Cycle;
  logic       tick;
  logic [1:0] active_mode;
  logic       mode_change;

  int assertCount = 0;
  int failCount   = 0;
  int expEdges;

  activity_controller #(
    .TICK_DIV  (TICK_DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run     (btn_run),
    .btn_walk    (btn_walk),
    .btn_cycle   (btn_cycle),
    .btn_stop    (btn_stop),
    .Run         (Run),
    .Walk        (Walk),
    .Cycle       (Cycle),
    .tick        (tick),
    .active_mode (active_mode),
    .mode_change (mode_change)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Edges seen since reset released; a tick is expected after every tenth.
  always @(posedge clk or posedge rst) begin
    if (rst) expEdges <= 0;
    else     expEdges <= expEdges + 1;
  end

  function automatic logic expTick();
    return (expEdges > 0) && (expEdges % TICK_DIV == 0);
  endfunction

  // Button vector order: {stop, cycle, walk, run}.
  task automatic applyStimulus(input logic [3:0] b);
    btn_run   = b[0];
    btn_walk  = b[1];
    btn_cycle = b[2];
    btn_stop  = b[3];
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Holds buttons for 'width' sampling edges, then releases and keeps
  // stepping until 'total' edges have passed, counting mode_change pulses.
  task automatic pressAndWait(input logic [3:0] b, input int width,
                              input int total, output int mcCount);
    mcCount = 0;
    applyStimulus(b);
    for (int e = 0; e < total; e++) begin
      stepCycle();
      if (e == width - 1) applyStimulus(4'b0000);
      if (mode_change) mcCount++;
    end
  endtask

  // Reset values, then 50 idle cycles of free-running ticks.
  task automatic test_reset();
    int ticks;
    ticks = 0;
    rst = 1'b0;
    applyStimulus(4'b0000);
    #1 rst = 1'b1;
    #1;
    assertCount++;
    if ({Run, Walk, Cycle, tick, mode_change, active_mode} !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL reset_async got=%b exp=0000000",
               {Run, Walk, Cycle, tick, mode_change, active_mode});
    end
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      assertCount++;
      if ({Run, Walk, Cycle, tick, mode_change, active_mode} !== 7'b0) begin
        failCount++;
        $display("[TB] FAIL reset_held cyc=%0d got=%b exp=0000000", c,
                 {Run, Walk, Cycle, tick, mode_change, active_mode});
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      stepCycle();
      if (tick) ticks++;
      assertCount++;
      if (tick !== expTick()) begin
        failCount++;
        $display("[TB] FAIL idle_tick cyc=%0d got=%b exp=%b", c, tick, expTick());
      end
      assertCount++;
      if ({Run, Walk, Cycle, active_mode} !== 5'b0) begin
        failCount++;
        $display("[TB] FAIL idle_outputs cyc=%0d got=%b exp=00000", c,
                 {Run, Walk, Cycle, active_mode});
      end
    end
    assertCount++;
    if (ticks !== 5) begin
      failCount++;
      $display("[TB] FAIL idle_tick_count got=%0d exp=5", ticks);
    end
  endtask

  // Held run button: RUN at edge 6, one mode_change, Run follows tick.
  task automatic test_run_hold();
    int mc;
    mc = 0;
    applyStimulus(4'b0001);
    for (int e = 0; e < 20; e++) begin
      stepCycle();
      if (mode_change) mc++;
      if (e == 5) begin
        assertCount++;
        if (active_mode !== 2'b00) begin
          failCount++;
          $display("[TB] FAIL run_latency_early got=%b exp=00", active_mode);
        end
      end
      if (e == 6) begin
        assertCount++;
        if ({active_mode, mode_change} !== 3'b011) begin
          failCount++;
          $display("[TB] FAIL run_latency_edge6 got=%b exp=011",
                   {active_mode, mode_change});
        end
      end
      if (e >= 6) begin
        assertCount++;
        if ({Run, Walk, Cycle} !== {expTick(), 2'b00}) begin
          failCount++;
          $display("[TB] FAIL run_pulses cyc=%0d got=%b exp=%b", e,
                   {Run, Walk, Cycle}, {expTick(), 2'b00});
        end
      end
    end
    applyStimulus(4'b0000);
    for (int e = 0; e < 10; e++) begin
      stepCycle();
      if (mode_change) mc++;
    end
    assertCount++;
    if (mc !== 1 || active_mode !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL run_hold_single got mc=%0d mode=%b exp mc=1 mode=01",
               mc, active_mode);
    end
  endtask

  // Short pulses and a bouncing press must not change the mode.
  task automatic test_glitch();
    int mc;
    int mcTotal;
    pressAndWait(4'b0001, 3, 12, mc);
    assertCount++;
    if (mc !== 0 || active_mode !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL glitch_3cyc got mc=%0d mode=%b exp mc=0 mode=01",
               mc, active_mode);
    end
    mcTotal = 0;
    applyStimulus(4'b0001);
    for (int e = 0; e < 3; e++) begin stepCycle(); if (mode_change) mcTotal++; end
    applyStimulus(4'b0000);
    stepCycle();
    if (mode_change) mcTotal++;
    applyStimulus(4'b0001);
    for (int e = 0; e < 3; e++) begin stepCycle(); if (mode_change) mcTotal++; end
    applyStimulus(4'b0000);
    for (int e = 0; e < 10; e++) begin stepCycle(); if (mode_change) mcTotal++; end
    assertCount++;
    if (mcTotal !== 0 || active_mode !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL glitch_bounce got mc=%0d mode=%b exp mc=0 mode=01",
               mcTotal, active_mode);
    end
  endtask

  // Pause toggle with a minimum-width press, then cycle, then stop.
  task automatic test_toggle();
    int mc;
    int mcTotal;
    mcTotal = 0;
    pressAndWait(4'b0001, DB_CYCLES, 12, mc);
    mcTotal += mc;
    assertCount++;
    if (active_mode !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL toggle_run_pause got=%b exp=00", active_mode);
    end
    pressAndWait(4'b0100, 6, 14, mc);
    mcTotal += mc;
    assertCount++;
    if (active_mode !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL toggle_cycle got=%b exp=11", active_mode);
    end
    pressAndWait(4'b1000, 5, 12, mc);
    mcTotal += mc;
    assertCount++;
    if (active_mode !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL toggle_stop got=%b exp=00", active_mode);
    end
    assertCount++;
    if (mcTotal !== 3) begin
      failCount++;
      $display("[TB] FAIL toggle_mc_count got=%0d exp=3", mcTotal);
    end
  endtask

  // Simultaneous presses resolve by priority.
  task automatic test_simultaneous();
    int mc;
    pressAndWait(4'b0001, 5, 12, mc);
    assertCount++;
    if (active_mode !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL simul_setup got=%b exp=01", active_mode);
    end
    pressAndWait(4'b1110, 6, 14, mc);
    assertCount++;
    if (active_mode !== 2'b00 || mc !== 1) begin
      failCount++;
      $display("[TB] FAIL simul_stop_wins got mode=%b mc=%0d exp mode=00 mc=1",
               active_mode, mc);
    end
    pressAndWait(4'b0110, 6, 14, mc);
    assertCount++;
    if (active_mode !== 2'b10 || mc !== 1) begin
      failCount++;
      $display("[TB] FAIL simul_walk_wins got mode=%b mc=%0d exp mode=10 mc=1",
               active_mode, mc);
    end
    for (int e = 0; e < 12; e++) begin
      stepCycle();
      assertCount++;
      if ({Run, Walk, Cycle} !== {1'b0, expTick(), 1'b0}) begin
        failCount++;
        $display("[TB] FAIL walk_pulses cyc=%0d got=%b exp=%b", e,
                 {Run, Walk, Cycle}, {1'b0, expTick(), 1'b0});
      end
    end
  endtask

  // Reset between edges while a Run pulse is high, with run held throughout.
  task automatic test_reset_midrun();
    int mc;
    int firstTick;
    logic found;
    pressAndWait(4'b0001, 5, 12, mc);
    assertCount++;
    if (active_mode !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL midrun_setup got=%b exp=01", active_mode);
    end
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      stepCycle();
      if (tick) found = 1'b1;
    end
    assertCount++;
    if (!found || Run !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midrun_wait_tick got found=%b Run=%b exp 1 1", found, Run);
    end
    applyStimulus(4'b0001);
    #2 rst = 1'b1;
    #1;
    assertCount++;
    if ({Run, Walk, Cycle, tick, mode_change, active_mode} !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL midrun_reset_immediate got=%b exp=0000000",
               {Run, Walk, Cycle, tick, mode_change, active_mode});
    end
    @(posedge clk);
    #1;
    stepCycle();
    rst = 1'b0;
    mc = 0;
    firstTick = -1;
    for (int e = 0; e < 15; e++) begin
      stepCycle();
      if (mode_change) mc++;
      if (tick && firstTick < 0) firstTick = e;
      assertCount++;
      if (tick !== expTick()) begin
        failCount++;
        $display("[TB] FAIL post_reset_tick cyc=%0d got=%b exp=%b", e, tick, expTick());
      end
      if (e == 5) begin
        assertCount++;
        if (active_mode !== 2'b00) begin
          failCount++;
          $display("[TB] FAIL held_through_reset_early got=%b exp=00", active_mode);
        end
      end
      if (e == 6) begin
        assertCount++;
        if ({active_mode, mode_change} !== 3'b011) begin
          failCount++;
          $display("[TB] FAIL held_through_reset_edge6 got=%b exp=011",
                   {active_mode, mode_change});
        end
      end
    end
    applyStimulus(4'b0000);
    assertCount++;
    if (firstTick !== 9 || mc !== 1) begin
      failCount++;
      $display("[TB] FAIL post_reset_first_tick got tickEdge=%0d mc=%0d exp 9 1",
               firstTick, mc);
    end
  endtask

  initial begin
    test_reset();
    test_run_hold();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/activity_controller.md
ACTIVITY_CONTROLLER -- requirements
Module: activity_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter TICK_DIV, default 100: clk cycles per one-second tick, legal range 2..65535.
REQ-003 Parameter DB_CYCLES, default 4: consecutive stable cycles required to accept a button level, legal range 2..255.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 btn_run, btn_walk, btn_cycle, btn_stop  in  1 each  raw asynchronous push-buttons, active-high.
REQ-007 Run, Walk, Cycle  out  1 each  one-cycle count-enable pulses that drive the stopwatch activity inputs.
REQ-008 tick  out  1  one-cycle pulse once every TICK_DIV cycles.
REQ-009 active_mode  out  2  current state: 00 IDLE, 01 RUN, 10 WALK, 11 CYCLE.
REQ-010 mode_change  out  1  one-cycle pulse on every state change.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer; s is the second flop's output.
REQ-012 Each button SHALL have a debounced level d and a counter c. If s==d, c<=0. Else if c==DB_CYCLES-1, then d<=s and c<=0. Else c<=c+1.
REQ-013 A pulse whose synchronized width is shorter than DB_CYCLES cycles SHALL NOT change d.
REQ-014 A press is defined as d==1 while the registered previous value d_q==0; only rising edges count, so a held button produces exactly one press.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0. tick SHALL be registered and high for exactly the cycle after the count equals TICK_DIV-1.
REQ-016 The prescaler SHALL be free-running and independent of state.
REQ-017 FSM states are IDLE, RUN, WALK and CYCLE, and state transitions occur only on presses.
REQ-018 Transition rules:
- stop press: go to IDLE from any state.
- Activity press in a different state: go directly to that activity.
- Activity press in the same state: go to IDLE (pause toggle).
REQ-019 Simultaneous presses in one cycle SHALL resolve by priority stop > run > walk > cycle; lower-priority presses are discarded.
REQ-020 Run = (state==RUN) & tick, Walk = (state==WALK) & tick, Cycle = (state==CYCLE) & tick. Both operands are registered and the outputs are mutually exclusive.
REQ-021 On a cycle where tick and a state change coincide, the Run/Walk/Cycle outputs SHALL use the pre-transition state.
REQ-022 mode_change SHALL be registered and high for one cycle, the cycle after the state register changes. A press that leaves the state unchanged SHALL NOT pulse it.
REQ-023 Latency: let edge 0 be the first edge that samples a raw button high, held stable. Then d rises at edge DB_CYCLES+1 and the state updates at edge DB_CYCLES+2.
REQ-024 Button activity during an in-progress debounce SHALL restart the count whenever s returns to d.

Reset
REQ-025 While rst is high, regardless of clk, the following SHALL all be 0:
- state (IDLE), active_mode 00
- Run, Walk, Cycle, tick, mode_change
- all synchronizer flops, d, d_q and c
- the prescaler count
REQ-026 Deasserting rst mid-debounce or mid-prescale SHALL restart both from zero. A button held through reset SHALL register one press after the REQ-023 latency, measured from the first post-reset edge.

Verification (TICK_DIV=10, DB_CYCLES=4)
REQ-027 Reset only, run 50 cycles -> tick every 10th cycle, Run/Walk/Cycle stay 0, active_mode 00.
REQ-028 btn_run high 20 cycles -> active_mode 01 at edge 6, one mode_change pulse, then Run pulses coincident with every tick and Walk/Cycle stay 0.
REQ-029 btn_run 3-cycle glitch -> no state change and no mode_change.
REQ-030 In RUN, press btn_run again -> IDLE (00); then press btn_cycle -> 11; then press btn_stop -> 00; three mode_change pulses in total.
REQ-031 btn_stop, btn_walk and btn_cycle rise on the same edge while in RUN -> IDLE. In IDLE, btn_walk and btn_cycle together -> WALK (10).
REQ-032 rst asserted mid-RUN between clock edges -> all outputs 0 immediately. After release, the first tick occurs 10 cycles later.
